// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID check master.
// No logic: state encoding and the two slave word addresses.
// No backpressure: declarations only.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only bus between the check master and the system-ID slave.
// No latency of its own: plain wires.
// Backpressure: slave stalls with avm_waitrequest; data qualified by avm_readdatavalid.
interface sysid_check_master_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/sysid_check_master.sv
// Reads system-ID word 0 (ID) and word 1 (timestamp), compares against build-time values.
// Latency: start to done = 6 cycles with a zero-wait, one-cycle-latency slave.
// Backpressure: request held stable under waitrequest; any bus state aborts after TIMEOUT_CYCLES.
module sysid_check_master
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5AA4_65A5,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          TO_W           = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    sysid_check_master_if.master        avm,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] to_cnt;

    logic            accept;
    logic            rdv;
    logic            to_hit;
    logic            in_bus;
    logic            leg_exit;
    logic            to_event;
    logic            match;

    logic            read_nxt;
    logic            addr_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            pass_nxt;
    logic            fail_nxt;
    logic            timeout_nxt;
    logic [31:0]     id_nxt;
    logic [31:0]     ts_nxt;

    // Bus-level events; a state's exit condition always beats the timeout in the same cycle.
    always_comb begin
        accept = avm.avm_read && !avm.avm_waitrequest;
        rdv    = avm.avm_readdatavalid;
        to_hit = (to_cnt == TO_LAST);
        in_bus = state inside {REQ_ID, WAIT_ID, REQ_TS, WAIT_TS};
        case (state)
            REQ_ID, REQ_TS:   leg_exit = accept;
            WAIT_ID, WAIT_TS: leg_exit = rdv;
            default:          leg_exit = 1'b0;
        endcase
        to_event = in_bus && !leg_exit && to_hit;
        match    = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: zero-latency data in the acceptance cycle skips the WAIT state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ_ID;
            end
            REQ_ID: begin
                if (accept)      state_nxt = rdv ? REQ_TS : WAIT_ID;
                else if (to_hit) state_nxt = FINISH;
            end
            WAIT_ID: begin
                if (rdv)         state_nxt = REQ_TS;
                else if (to_hit) state_nxt = FINISH;
            end
            REQ_TS: begin
                if (accept)      state_nxt = rdv ? FINISH : WAIT_TS;
                else if (to_hit) state_nxt = FINISH;
            end
            WAIT_TS: begin
                if (rdv)         state_nxt = FINISH;
                else if (to_hit) state_nxt = FINISH;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-state dwell counter: restarts on every state change, counts only in bus states.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state_nxt != state) begin
            to_cnt <= '0;
        end else if (in_bus) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // Next values of every registered output; a timeout pulses done itself so FINISH stays silent.
    always_comb begin
        read_nxt    = (state_nxt == REQ_ID) || (state_nxt == REQ_TS);
        addr_nxt    = ((state_nxt == REQ_TS) || (state_nxt == WAIT_TS)) ? ADDR_TS : ADDR_ID;
        busy_nxt    = (state_nxt != IDLE) && !to_event;
        done_nxt    = to_event || ((state == FINISH) && !timeout);
        pass_nxt    = pass;
        fail_nxt    = fail;
        timeout_nxt = timeout;
        id_nxt      = id_value;
        ts_nxt      = ts_value;

        if ((state == IDLE) && start) begin
            pass_nxt    = 1'b0;
            fail_nxt    = 1'b0;
            timeout_nxt = 1'b0;
        end
        if (to_event) begin
            pass_nxt    = 1'b0;
            fail_nxt    = 1'b0;
            timeout_nxt = 1'b1;
        end
        if ((state == FINISH) && !timeout) begin
            pass_nxt = match;
            fail_nxt = !match;
        end
        if (((state == REQ_ID) && accept && rdv) || ((state == WAIT_ID) && rdv)) begin
            id_nxt = avm.avm_readdata;
        end
        if (((state == REQ_TS) && accept && rdv) || ((state == WAIT_TS) && rdv)) begin
            ts_nxt = avm.avm_readdata;
        end
    end

    // Output registers; reset drops an in-flight read immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avm.avm_read    <= 1'b0;
            avm.avm_address <= ADDR_ID;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            id_value        <= '0;
            ts_value        <= '0;
        end else begin
            avm.avm_read    <= read_nxt;
            avm.avm_address <= addr_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            pass            <= pass_nxt;
            fail            <= fail_nxt;
            timeout         <= timeout_nxt;
            id_value        <= id_nxt;
            ts_value        <= ts_nxt;
        end
    end

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that queries the system-ID slave and checks it against build-time expected values.
- Issues two single-word reads: word 0 (ID) and word 1 (timestamp).
- Latches both values, compares them, and reports pass, fail or timeout.
- Sits beside the HPS/bus bridge in the computer system; its status feeds the boot-check logic and LEDs.

Parameters:
- EXPECTED_ID, 32'h0000_0000, required value at word address 0.
- EXPECTED_TS, 32'h5AA4_65A5, required value at word address 1.
- TIMEOUT_CYCLES, 255, maximum cycles spent in any one bus state before abort (1..65535).
- TO_W, 16, width of the timeout counter.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a check sequence.
- avm_address, output, 1, word address to the slave.
- avm_read, output, 1, read request.
- avm_waitrequest, input, 1, slave stall.
- avm_readdata, input, 32, read data.
- avm_readdatavalid, input, 1, read data qualifier.
- busy, output, 1, sequence in progress.
- done, output, 1, one-cycle pulse at sequence end.
- pass, output, 1, sticky; last sequence matched both words.
- fail, output, 1, sticky; last sequence had a mismatch.
- timeout, output, 1, sticky; last sequence aborted on timeout.
- id_value, output, 32, latched word 0.
- ts_value, output, 32, latched word 1.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE.
  - All outputs 0: avm_address=0, avm_read=0, busy=0, done=0, pass/fail/timeout=0, id_value=ts_value=0.
  - Timeout counter cleared.
- Reset mid-transfer drops avm_read immediately. No recovery of an outstanding read is attempted.
- States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
- IDLE:
  - start=1 -> REQ_ID; clear pass/fail/timeout; busy=1 from the next cycle.
  - start while busy is ignored.
- REQ_ID:
  - avm_read=1, avm_address=0, both registered and held stable while avm_waitrequest=1.
  - Request accepted in the cycle where avm_read=1 and avm_waitrequest=0 -> WAIT_ID; avm_read=0 next cycle.
- Same-cycle data: if avm_readdatavalid=1 in the acceptance cycle (zero-latency slave), the data is captured and the FSM goes directly to REQ_TS.
- WAIT_ID: on avm_readdatavalid=1, id_value<=avm_readdata -> REQ_TS.
- REQ_TS, WAIT_TS: identical to REQ_ID and WAIT_ID with avm_address=1; capture to ts_value -> FINISH.
- FINISH (one cycle):
  - done=1, busy=0.
  - pass=(id_value==EXPECTED_ID)&&(ts_value==EXPECTED_TS); fail=!pass.
  - -> IDLE.
- Timeout:
  - Counter clears on each state entry and increments every cycle in REQ_*/WAIT_*.
  - When counter==TIMEOUT_CYCLES-1 and the exit condition is not met: avm_read<=0, timeout=1, pass=fail=0, go to FINISH with done pulsed.
  - The exit condition takes priority over timeout in the same cycle.
- After a timeout, a late avm_readdatavalid in IDLE is ignored; id_value/ts_value keep their last captured values.
- Full 32-bit equality compare; no masking.
- Read latency: a request and its data are never outstanding more than one at a time (no pipelining).
- Sequence latency with zero-wait, one-cycle-latency slave: start to done = 6 cycles.

Decomposition:
- Shared package sysid_pkg:
  - state enum (6 states, 3-bit encoding).
  - ADDR_ID=1'b0, ADDR_TS=1'b1.
- Sub-module sysid_bus_read: one request/response leg (REQ+WAIT with timeout counter), instanced once and sequenced by the top FSM via an address input. Natural but optional.
- All outputs registered.

Test Plan:
- Zero-wait slave returning 0 then 32'h5AA4_65A5, readdatavalid one cycle after accept; pulse start -> done at cycle 6, pass=1, fail=0, id_value=0, ts_value=32'h5AA4_65A5.
- Slave returns 32'h5AA4_65A4 for word 1 -> done, fail=1, pass=0, ts_value=32'h5AA4_65A4.
- waitrequest held 3 cycles on each request -> avm_read/avm_address stable throughout; sequence completes 6 cycles later than baseline; pass=1.
- Slave never asserts readdatavalid, TIMEOUT_CYCLES=16 -> timeout=1 and done 16 cycles after WAIT_ID entry; avm_read=0; pass=fail=0.
- Assert reset while avm_read=1 in REQ_TS -> avm_read=0 and busy=0 in the same cycle. A subsequent start yields a clean pass.
- start pulsed repeatedly while busy, plus readdatavalid in the acceptance cycle -> single sequence, one done pulse, correct capture with no WAIT cycle.
